decoder_2to4_seq: RTL and testbench

DECODER_2TO4_SEQ -- requirements
Module: decoder_2to4_seq

---
 rtl/decoder_2to4_seq_if.sv | 29 ++
 rtl/decoder_2to4_seq.sv | 139 +++++++++++++
 tb/tb_decoder_2to4_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_2to4_seq_if.sv
// Handshake and output bundle for decoder_2to4_seq.
// The master side supplies codes; the slave side (the decoder) returns
// ready, the one-hot lines and the busy/done status.
interface decoder_2to4_seq_if;
    logic [1:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic [3:0] Y;
    logic       busy;
    logic       done;

    modport master (
        output code_in,
        output code_valid,
        input  code_ready,
        input  Y,
        input  busy,
        input  done
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output code_ready,
        output Y,
        output busy,
        output done
    );
endinterface

// File: rtl/decoder_2to4_seq.sv
// decoder_2to4_seq: sequential 2-to-4 decoder.
// An accepted code drives its one-hot line for HOLD_CYCLES cycles, followed
// by a single zero cycle that pulses done. One further code can wait in a
// 1-deep pending buffer so back-to-back codes stream without loss.
// Optional feature: define DECODER_ENABLE_PIN_EN to add an input en that
// blanks Y, drops code_ready and freezes the hold counter while low.
module decoder_2to4_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef DECODER_ENABLE_PIN_EN
    input  logic en,
`endif
    decoder_2to4_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Counter is loaded with the number of cycles remaining after the first.
    localparam logic [7:0] HOLD_LOAD_C = 8'(HOLD_CYCLES - 32'd1);

    // Binary code to one-hot line mapping.
    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        logic [3:0] y;
        case (code)
            2'b00:   y = 4'b0001;
            2'b01:   y = 4'b0010;
            2'b10:   y = 4'b0100;
            2'b11:   y = 4'b1000;
            default: y = 4'b0000;
        endcase
        return y;
    endfunction

    state_t     state_r;
    logic [7:0] cnt_r;
    logic [3:0] y_r;
    logic       pend_full_r;
    logic [1:0] pend_code_r;
    logic       done_r;
    logic       busy_r;

    logic       en_s;
    logic       ready_s;
    logic       accept_s;

`ifdef DECODER_ENABLE_PIN_EN
    assign en_s = en;
`else
    assign en_s = 1'b1;
`endif

    // A new code can only be taken while the pending slot is free.
    assign ready_s  = ~pend_full_r & en_s;
    assign accept_s = bus.code_valid & ready_s;

    assign bus.code_ready = ready_s;
    assign bus.Y          = y_r & {4{en_s}};
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    // Main sequencer: drive / gap timing, pending buffer and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            y_r         <= 4'b0000;
            pend_full_r <= 1'b0;
            pend_code_r <= 2'b00;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_DRIVE;
                        y_r     <= decode_onehot(bus.code_in);
                        cnt_r   <= HOLD_LOAD_C;
                        busy_r  <= 1'b1;
                    end else begin
                        y_r    <= 4'b0000;
                        busy_r <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    // A code arriving while driving waits in the pending slot.
                    if (accept_s) begin
                        pend_full_r <= 1'b1;
                        pend_code_r <= bus.code_in;
                    end else begin
                        pend_full_r <= pend_full_r;
                    end
                    if (en_s) begin
                        if (cnt_r == 8'd0) begin
                            state_r <= ST_GAP;
                            y_r     <= 4'b0000;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_GAP: begin
                    // Pending code has priority; the slot is full so no
                    // fresh code can be accepted on this edge anyway.
                    if (pend_full_r) begin
                        state_r     <= ST_DRIVE;
                        y_r         <= decode_onehot(pend_code_r);
                        cnt_r       <= HOLD_LOAD_C;
                        pend_full_r <= 1'b0;
                    end else if (accept_s) begin
                        state_r <= ST_DRIVE;
                        y_r     <= decode_onehot(bus.code_in);
                        cnt_r   <= HOLD_LOAD_C;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 8'd0;
                    y_r         <= 4'b0000;
                    pend_full_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Bench for decoder_2to4_seq: two instances (HOLD_CYCLES 4 and 1) share the
// same stimulus; a cycle model per instance is compared every cycle, and
// directed traces pin the model with hand-derived waveforms.
module tb_decoder_2to4_seq;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic [1:0] code_in    = 2'b00;
    logic       code_valid = 1'b0;
    logic       en         = 1'b1;

    always #5 clk = ~clk;

    decoder_2to4_seq_if bus4 ();
    decoder_2to4_seq_if bus1 ();

    assign bus4.code_in    = code_in;
    assign bus4.code_valid = code_valid;
    assign bus1.code_in    = code_in;
    assign bus1.code_valid = code_valid;

    decoder_2to4_seq #(.HOLD_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
`ifdef DECODER_ENABLE_PIN_EN
        .en  (en),
`endif
        .bus (bus4)
    );

    decoder_2to4_seq #(.HOLD_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
`ifdef DECODER_ENABLE_PIN_EN
        .en  (en),
`endif
        .bus (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: remaining high cycles, gap flag, current code, waiting code.
    int          hold     [2] = '{4, 1};
    int          m_rem    [2] = '{0, 0};
    bit          m_gap    [2] = '{1'b0, 1'b0};
    logic [1:0]  m_cur    [2] = '{2'b00, 2'b00};
    bit          m_wn     [2] = '{1'b0, 1'b0};
    logic [1:0]  m_wq     [2] = '{2'b00, 2'b00};
    bit          acc_flag [2] = '{1'b0, 1'b0};
    logic [1:0]  acc_q [$];
    logic [3:0]  last_nz = 4'b0000;

    bit          trace_en  = 1'b0;
    int          trace_idx = 0;
    logic [3:0]  tr_y    [2][64];
    bit          tr_done [2][64];
    bit          tr_busy [2][64];
    bit          tr_rdy  [2][64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit rdy;
            bit acc;
            if (rst) begin
                m_rem[i] = 0; m_gap[i] = 1'b0; m_wn[i] = 1'b0; acc_flag[i] = 1'b0;
                if (i == 0) acc_q.delete();
            end else begin
                rdy = !m_wn[i] && en;
                acc = code_valid && rdy;
                acc_flag[i] = acc;
                if (acc && i == 0) acc_q.push_back(code_in);
                if (m_rem[i] > 0) begin
                    if (en) begin
                        m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) m_gap[i] = 1'b1;
                    end
                    if (acc) begin m_wq[i] = code_in; m_wn[i] = 1'b1; end
                end else if (m_gap[i]) begin
                    m_gap[i] = 1'b0;
                    if (m_wn[i]) begin m_cur[i] = m_wq[i]; m_wn[i] = 1'b0; m_rem[i] = hold[i]; end
                    else if (acc) begin m_cur[i] = code_in; m_rem[i] = hold[i]; end
                end else if (acc) begin
                    m_cur[i] = code_in; m_rem[i] = hold[i];
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic compare_cycle();
        logic [3:0] y_d    [2];
        logic       done_d [2];
        logic       busy_d [2];
        logic       rdy_d  [2];
        y_d[0] = bus4.Y; done_d[0] = bus4.done; busy_d[0] = bus4.busy; rdy_d[0] = bus4.code_ready;
        y_d[1] = bus1.Y; done_d[1] = bus1.done; busy_d[1] = bus1.busy; rdy_d[1] = bus1.code_ready;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] y_exp;
            y_exp = (m_rem[i] > 0 && en) ? (4'b0001 << m_cur[i]) : 4'b0000;
            check($sformatf("y[%0d]", i),     32'(y_d[i]),    32'(y_exp));
            check($sformatf("done[%0d]", i),  32'(done_d[i]), 32'(m_gap[i]));
            check($sformatf("busy[%0d]", i),  32'(busy_d[i]), 32'((m_rem[i] > 0) || m_gap[i]));
            check($sformatf("ready[%0d]", i), 32'(rdy_d[i]),  32'(!m_wn[i] && en));
            check($sformatf("onehot[%0d]", i), 32'($countones(y_d[i]) <= 1), 32'd1);
            if (trace_en && trace_idx < 64) begin
                tr_y[i][trace_idx]    = y_d[i];
                tr_done[i][trace_idx] = done_d[i];
                tr_busy[i][trace_idx] = busy_d[i];
                tr_rdy[i][trace_idx]  = rdy_d[i];
            end
        end
        if (trace_en && trace_idx < 64) trace_idx++;
        // Order scoreboard: each done closes the oldest accepted code.
        if (done_d[0] === 1'b1) begin
            check("sb_nonempty", 32'(acc_q.size() > 0), 32'd1);
            if (acc_q.size() > 0) begin
                logic [1:0] c;
                c = acc_q.pop_front();
                check("sb_order", 32'(last_nz), 32'(4'b0001 << c));
            end
        end
        if (y_d[0] !== 4'b0000) last_nz = y_d[0];
    endtask

    initial forever begin
        @(negedge clk);
        compare_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_trace();
        trace_idx = 0;
        trace_en  = 1'b1;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 100 && !idle; k++) begin
            idle = (m_rem[0] == 0) && !m_gap[0] && !m_wn[0] &&
                   (m_rem[1] == 0) && !m_gap[1] && !m_wn[1];
            if (!idle) tick();
        end
        check("idle_timeout", 32'(idle), 32'd1);
    endtask

    task automatic send_hold(input logic [1:0] c);
        code_in    = c;
        code_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc_flag[0]) break;
        end
        check("accept_timeout", 32'(acc_flag[0]), 32'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_y",     32'(bus4.Y),          32'h0);
        check("rst_busy",  32'(bus4.busy),       32'h0);
        check("rst_done",  32'(bus4.done),       32'h0);
        check("rst_ready", 32'(bus4.code_ready), 32'h1);

        // Single code 10, accepted on first edge after reset release
        rst = 1'b0; code_in = 2'b10; code_valid = 1'b1;
        tick();
        check("first_accept", 32'(acc_flag[0]), 32'd1);
        code_valid = 1'b0;
        start_trace();
        repeat (7) tick();
        trace_en = 1'b0;
        for (int k = 0; k < 4; k++) check($sformatf("single_y%0d", k), 32'(tr_y[0][k]), 32'(4'b0100));
        check("single_gap_y",    32'(tr_y[0][4]),    32'h0);
        check("single_gap_done", 32'(tr_done[0][4]), 32'h1);
        check("single_busy_low", 32'(tr_busy[0][5]), 32'h0);

        // Back-to-back 00,01,10,11 with valid held
        wait_idle();
        send_hold(2'b00);
        start_trace();
        send_hold(2'b01);
        send_hold(2'b10);
        send_hold(2'b11);
        code_valid = 1'b0;
        repeat (10) tick();
        trace_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] e;
            e = 4'b0001 << i;
            for (int k = 0; k < 4; k++)
                check($sformatf("b2b_y%0d_%0d", i, k), 32'(tr_y[0][5*i+k]), 32'(e));
            check($sformatf("b2b_gap%0d", i),  32'(tr_y[0][5*i+4]),    32'h0);
            check($sformatf("b2b_done%0d", i), 32'(tr_done[0][5*i+4]), 32'h1);
        end
        check("b2b_ready_full", 32'(tr_rdy[0][1]), 32'h0);
        check("b2b_ready_free", 32'(tr_rdy[0][5]), 32'h1);

        // HOLD_CYCLES=1 instance: codes 11 then 00
        wait_idle();
        code_in = 2'b11; code_valid = 1'b1;
        tick();
        code_in = 2'b00;
        start_trace();
        tick();
        code_valid = 1'b0;
        repeat (5) tick();
        trace_en = 1'b0;
        check("h1_y0",    32'(tr_y[1][0]),    32'(4'b1000));
        check("h1_y1",    32'(tr_y[1][1]),    32'h0);
        check("h1_done1", 32'(tr_done[1][1]), 32'h1);
        check("h1_y2",    32'(tr_y[1][2]),    32'(4'b0001));
        check("h1_y3",    32'(tr_y[1][3]),    32'h0);
        check("h1_done3", 32'(tr_done[1][3]), 32'h1);

        // Reset during second DRIVE cycle of 01 with 11 pending
        wait_idle();
        code_in = 2'b01; code_valid = 1'b1;
        tick();
        code_in = 2'b11;
        tick();
        code_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_y",     32'(bus4.Y),          32'h0);
        check("abort_busy",  32'(bus4.busy),       32'h0);
        check("abort_ready", 32'(bus4.code_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        start_trace();
        repeat (8) tick();
        trace_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("abort_quiet_y%0d", k),    32'(tr_y[0][k]),    32'h0);
            check($sformatf("abort_quiet_done%0d", k), 32'(tr_done[0][k]), 32'h0);
        end

`ifdef DECODER_ENABLE_PIN_EN
        // en low for 3 cycles mid-DRIVE of code 01
        wait_idle();
        code_in = 2'b01; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        start_trace();
        tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (6) tick();
        trace_en = 1'b0;
        begin
            logic [3:0] exp_en [8];
            int highs;
            exp_en = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
            highs = 0;
            for (int k = 0; k < 8; k++) begin
                check($sformatf("en_y%0d", k), 32'(tr_y[0][k]), 32'(exp_en[k]));
                if (tr_y[0][k] != 4'b0000) highs++;
            end
            check("en_high_count", 32'(highs), 32'd4);
            check("en_done", 32'(tr_done[0][7]), 32'h1);
        end
`endif

        // Random valid/code traffic
        wait_idle();
        for (int n = 0; n < 200; n++) begin
            code_valid = 1'($urandom_range(0, 1));
            code_in    = 2'($urandom_range(0, 3));
`ifdef DECODER_ENABLE_PIN_EN
            en         = ($urandom_range(0, 7) != 0);
`endif
            tick();
        end
        code_valid = 1'b0;
        en = 1'b1;
        wait_idle();
        repeat (2) tick();
        check("sb_drained", 32'(acc_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
